// File: rtl/mul_div_ext.sv
// Iterative RV32M multiply/divide extension unit retiring BITS_PER_CYCLE bits per cycle.
// Optional macro MUL_DIV_EXT_DIV_EN adds the restoring divider; without it divide ops return 0.
module mul_div_ext #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       func3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             done,
  output logic             busy
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if ((BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4) ||
        (WIDTH % BITS_PER_CYCLE != 0)) begin : g_bad_cfg
      $error("mul_div_ext: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_CALC = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [2:0]       r_func3;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_done;
`ifdef MUL_DIV_EXT_DIV_EN
  logic             r_neg_r;
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_PREP;
        end
      end
      S_PREP: begin
        busy = 1'b1;
`ifdef MUL_DIV_EXT_DIV_EN
        w_state_next = S_CALC;
`else
        w_state_next = r_func3[2] ? S_FIX : S_CALC;
`endif
      end
      S_CALC: begin
        busy = 1'b1;
        // Counter reaches zero on this edge after the Nth CALC cycle.
        if (r_cnt == CNT_ONE) begin
          w_state_next = S_FIX;
        end
      end
      S_FIX: begin
        busy         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- PREP
  logic             w_a_signed;
  logic             w_b_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (r_func3)
      3'b001: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      3'b010: w_a_signed = 1'b1;
      3'b100, 3'b110: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      default: begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
      end
    endcase
    w_a_neg  = w_a_signed & r_a[WIDTH-1];
    w_b_neg  = w_b_signed & r_b[WIDTH-1];
    w_a_mag  = w_a_neg ? -r_a : r_a;
    w_b_mag  = w_b_neg ? -r_b : r_b;
    w_b_zero = (r_b == '0);
  end

  // ---------------------------------------------------------------- CALC
  logic [WIDTH-1:0] w_hi_step;
  logic [WIDTH-1:0] w_lo_step;
  logic [WIDTH:0]   w_sum;
`ifdef MUL_DIV_EXT_DIV_EN
  logic [WIDTH:0]   w_trial;
`endif

  // Multiply: r_lo holds the multiplier and shifts right under the growing product.
  // Divide: r_lo holds the dividend shifting left into r_hi while quotient bits fill from the right.
  always_comb begin
    w_hi_step = r_hi;
    w_lo_step = r_lo;
    w_sum     = '0;
`ifdef MUL_DIV_EXT_DIV_EN
    w_trial   = '0;
`endif
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
`ifdef MUL_DIV_EXT_DIV_EN
      if (r_func3[2]) begin
        w_trial   = {w_hi_step, w_lo_step[WIDTH-1]};
        w_lo_step = {w_lo_step[WIDTH-2:0], 1'b0};
        if (w_trial >= {1'b0, r_mcand}) begin
          w_trial      = w_trial - {1'b0, r_mcand};
          w_lo_step[0] = 1'b1;
        end
        w_hi_step = w_trial[WIDTH-1:0];
      end else
`endif
      begin
        w_sum     = {1'b0, w_hi_step} + (w_lo_step[0] ? {1'b0, r_mcand} : '0);
        w_lo_step = {w_sum[0], w_lo_step[WIDTH-1:1]};
        w_hi_step = w_sum[WIDTH:1];
      end
    end
  end

  // ---------------------------------------------------------------- FIX
  logic [2*WIDTH-1:0] w_prod_raw;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_result;

  always_comb begin
    w_prod_raw = {r_hi, r_lo};
    w_prod     = r_neg_q ? -w_prod_raw : w_prod_raw;
    w_result   = (r_func3[1:0] == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
    if (r_func3[2]) begin
`ifdef MUL_DIV_EXT_DIV_EN
      if (r_func3[1]) begin
        w_result = r_neg_r ? -r_hi : r_hi;
      end else begin
        w_result = r_neg_q ? -r_lo : r_lo;
      end
`else
      w_result = '0;
`endif
    end
  end

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_func3 <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_done  <= 1'b0;
`ifdef MUL_DIV_EXT_DIV_EN
      r_neg_r <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_func3 <= func3;
            r_a     <= a;
            r_b     <= b;
          end
        end
        S_PREP: begin
          r_mcand <= w_b_mag;
          r_lo    <= w_a_mag;
          r_hi    <= '0;
          r_cnt   <= CNT_LOAD;
          // Divide by zero keeps the all-ones quotient unsigned; the remainder follows the dividend.
          r_neg_q <= (w_a_neg ^ w_b_neg) & ~w_b_zero;
`ifdef MUL_DIV_EXT_DIV_EN
          r_neg_r <= w_a_neg;
`endif
        end
        S_CALC: begin
          r_hi  <= w_hi_step;
          r_lo  <= w_lo_step;
          r_cnt <= r_cnt - CNT_ONE;
        end
        S_FIX: begin
          r_res  <= w_result;
          r_done <= 1'b1;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign r    = r_res;
  assign done = r_done;

endmodule

// File: tb/tb_mul_div_ext.sv
// Directed bench for mul_div_ext: vector table over BPC=1 and BPC=4 instances plus
// hand sequences for reset, ignored start, back-to-back start and mid-operation abort.
module tb_mul_div_ext;

  localparam int W = 32;
`ifdef MUL_DIV_EXT_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start1 = 1'b0;
  logic         start4 = 1'b0;
  logic [2:0]   func3 = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] r1, r4;
  logic         done1, done4, busy1, busy4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul_div_ext #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .func3(func3), .a(a), .b(b),
    .r(r1), .done(done1), .busy(busy1)
  );

  mul_div_ext #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .func3(func3), .a(a), .b(b),
    .r(r4), .done(done4), .busy(busy4)
  );

  typedef struct {
    bit           use4;
    logic [2:0]   f;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [W-1:0] exp_r;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit use4, input logic [2:0] f, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic [W-1:0] exp_r);
    vec_t v;
    v.use4  = use4;
    v.f     = f;
    v.av    = av;
    v.bv    = bv;
    // Without the divider every divide op yields zero.
    v.exp_r = (f[2] && !DIV_ON) ? '0 : exp_r;
    vecs.push_back(v);
  endtask

  function automatic string op_name(input logic [2:0] f);
    case (f)
      3'b000:  return "MUL";
      3'b001:  return "MULH";
      3'b010:  return "MULHSU";
      3'b011:  return "MULHU";
      3'b100:  return "DIV";
      3'b101:  return "DIVU";
      3'b110:  return "REM";
      default: return "REMU";
    endcase
  endfunction

  function automatic int exp_latency(input bit use4, input logic [2:0] f);
    if (f[2] && !DIV_ON) return 2;
    return (use4 ? W / 4 : W) + 2;
  endfunction

  task automatic check(input string what, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", what, act, exp);
    end
  endtask

  // Waits for done on the chosen instance, counting edges since the start edge.
  task automatic wait_done(input bit use4, output int cyc, output logic busy_first);
    cyc        = 0;
    busy_first = 1'b0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) busy_first = use4 ? busy4 : busy1;
    end while (!(use4 ? done4 : done1) && cyc < 200);
  endtask

  task automatic run_op(input bit use4, input logic [2:0] f, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] exp_r);
    int   cyc;
    int   lat;
    logic bf;
    string nm;
    nm    = $sformatf("%s%s", op_name(f), use4 ? "_bpc4" : "_bpc1");
    lat   = exp_latency(use4, f);
    func3 = f;
    a     = av;
    b     = bv;
    if (use4) start4 = 1'b1;
    else      start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start4 = 1'b0;
    a      = $urandom;
    b      = $urandom;
    func3  = 3'($urandom);
    wait_done(use4, cyc, bf);
    check({nm, " latency"}, W'(cyc), W'(lat));
    check({nm, " result"}, use4 ? r4 : r1, exp_r);
    check({nm, " busy_first"}, W'(bf), W'(1));
    check({nm, " busy_at_done"}, W'(use4 ? busy4 : busy1), W'(0));
    $display("op %s a=%h b=%h r=%h cycles=%0d", nm, av, bv, use4 ? r4 : r1, cyc);
    @(posedge clk);
    #1;
    check({nm, " done_width"}, W'(use4 ? done4 : done1), W'(0));
    check({nm, " result_hold"}, use4 ? r4 : r1, exp_r);
  endtask

  initial begin
    int   cyc;
    int   first_done;
    int   done_cnt;
    logic bf;

    // Multiply vectors
    add_vec(0, 3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    add_vec(0, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    add_vec(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    add_vec(0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    add_vec(1, 3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780);
    add_vec(1, 3'b001, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF);
    add_vec(1, 3'b011, 32'h8000_0000, 32'd4,         32'd2);
    // Divide vectors
    add_vec(0, 3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    add_vec(0, 3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    add_vec(0, 3'b101, 32'd100,       32'd7,         32'd14);
    add_vec(0, 3'b111, 32'd100,       32'd7,         32'd2);
    add_vec(0, 3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF);
    add_vec(0, 3'b110, 32'd5,         32'd0,         32'd5);
    add_vec(0, 3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF);
    add_vec(0, 3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB);
    add_vec(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    add_vec(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    add_vec(0, 3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD);
    add_vec(0, 3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1);
    add_vec(0, 3'b100, 32'd10,        32'd2,         32'd5);
    add_vec(1, 3'b101, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF);
    add_vec(1, 3'b111, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F);
    add_vec(1, 3'b100, 32'd10,        32'd2,         32'd5);

    // Reset state
    #1 rst = 1'b0;
    #2;
    check("reset r1", r1, '0);
    check("reset done1", W'(done1), W'(0));
    check("reset busy1", W'(busy1), W'(0));
    check("reset r4", r4, '0);
    check("reset done4", W'(done4), W'(0));
    check("reset busy4", W'(busy4), W'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].use4, vecs[i].f, vecs[i].av, vecs[i].bv, vecs[i].exp_r);
    end

    // Start during busy is ignored; start in the done cycle is accepted.
    func3 = 3'b000; a = 32'd3; b = 32'd4; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0; a = $urandom; b = $urandom;
    cyc = 0; first_done = 0;
    while (first_done == 0 && cyc < 200) begin
      if (cyc == 9) begin
        func3 = 3'b000; a = 32'd5; b = 32'd5; start1 = 1'b1;
      end else begin
        start1 = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (done1) first_done = cyc;
    end
    check("ignored_start latency", W'(first_done), W'(W + 2));
    check("ignored_start result", r1, 32'd12);
    $display("op MUL_busy_start a=3 b=4 r=%h cycles=%0d", r1, first_done);
    func3 = 3'b000; a = 32'd5; b = 32'd5; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0; a = $urandom; b = $urandom;
    wait_done(1'b0, cyc, bf);
    check("back_to_back latency", W'(cyc), W'(W + 2));
    check("back_to_back result", r1, 32'd25);
    check("back_to_back busy", W'(bf), W'(1));
    $display("op MUL_back_to_back a=5 b=5 r=%h cycles=%0d", r1, cyc);

    // Asynchronous reset in the middle of CALC aborts the operation.
    @(posedge clk);
    #1;
    func3 = 3'b000; a = 32'h0000_1234; b = 32'h0000_0010; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    #2 rst = 1'b0;
    #1;
    check("abort r", r1, '0);
    check("abort busy", W'(busy1), W'(0));
    check("abort done", W'(done1), W'(0));
    @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done1) done_cnt++;
    end
    check("abort no_done", W'(done_cnt), W'(0));
    $display("op MUL_abort done_pulses=%0d", done_cnt);
    run_op(1'b0, 3'b000, 32'd2, 32'd3, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
